// File: rtl/conv_seq_pkg.sv
// Shared sizing helpers for the Conv1D step sequencer.
// Step totals and index widths are derived here so top and bench agree.
package conv_seq_pkg;

    function automatic int calc_main_steps(input int weight_nums, input int output_nums);
        return weight_nums * output_nums;
    endfunction

    function automatic int calc_total_steps(input int weight_nums, input int output_nums,
                                            input int pipe_stages);
        return weight_nums * output_nums + pipe_stages - 1;
    endfunction

    // Keeps a one-entry index at width 1 instead of a zero-width vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lvl_step_counter.sv
// One buffer-level counter: counts 0..LIMIT-1 while enabled, then wraps or saturates.
// All outputs are registered so they line up with the global step counter.
module lvl_step_counter #(
    parameter int LVL_W = 6,
    parameter int LIMIT = 19,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             clr,
    input  logic             run,
    input  logic             stall,
    output logic [LVL_W-1:0] count,
    output logic             last,
    output logic             wrap_pulse
);

    localparam logic [LVL_W-1:0] LAST_C = LVL_W'(LIMIT - 1);

    logic [LVL_W-1:0] cnt_q, cnt_nxt;
    logic             last_q;
    logic             pulse_q, pulse_nxt;

    if ((LIMIT < 1) || (LIMIT > (2 ** LVL_W))) begin : g_bad_limit
        $error("lvl_step_counter: LIMIT must be in 1..2**LVL_W");
    end

    always_comb begin
        cnt_nxt   = cnt_q;
        pulse_nxt = 1'b0;
        if (clr || !run) begin
            cnt_nxt = '0;
        end else if (!stall) begin
            if (cnt_q == LAST_C) begin
                // Saturate mode simply keeps the terminal value.
                if (WRAP) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt_q + LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q   <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            last_q  <= (cnt_nxt == LAST_C);
            pulse_q <= pulse_nxt;
        end
    end

    assign count      = cnt_q;
    assign last       = last_q;
    assign wrap_pulse = pulse_q;

endmodule

// File: rtl/conv_step_sequencer.sv
// Conv1D step sequencer: global step counter with tap/output index tracking, done/tail
// flags and NUM_LVL independent buffer-level counters.
module conv_step_sequencer
    import conv_seq_pkg::*;
#(
    parameter int                        PIPE_STAGES = 4,
    parameter int                        WEIGHT_NUMS = 4,
    parameter int                        OUTPUT_NUMS = 8,
    parameter int                        PARA_DEG    = 1,
    parameter int                        STEP_W      = 6,
    parameter int                        NUM_LVL     = 2,
    parameter int                        LVL_W       = 6,
    parameter logic [NUM_LVL*LVL_W-1:0]  LVL_LIMITS  = {6'd40, 6'd19},
    parameter logic [NUM_LVL-1:0]        LVL_WRAP    = 2'b00
) (
    input  logic                                clk,
    input  logic                                Reset_n,
    input  logic                                Comp_Reset,
    input  logic                                Computing,
    input  logic                                Stall,
    input  logic [NUM_LVL-1:0]                  Lvl_Ready,
    output logic [STEP_W-1:0]                   Step_Count,
    output logic [idx_w(WEIGHT_NUMS)-1:0]       Weight_Idx,
    output logic [idx_w(OUTPUT_NUMS)-1:0]       Output_Idx,
    output logic                                Tail_Active,
    output logic                                Comp_Done,
    output logic                                Done_Pulse,
    output logic [NUM_LVL*LVL_W-1:0]            Lvl_Count,
    output logic [NUM_LVL-1:0]                  Lvl_Last,
    output logic [NUM_LVL-1:0]                  Lvl_Wrap_Pulse
);

    localparam int WI_W        = idx_w(WEIGHT_NUMS);
    localparam int OI_W        = idx_w(OUTPUT_NUMS);
    localparam int MAIN_STEPS  = calc_main_steps(WEIGHT_NUMS, OUTPUT_NUMS);
    localparam int TOTAL_STEPS = calc_total_steps(WEIGHT_NUMS, OUTPUT_NUMS, PIPE_STAGES);

    localparam logic [STEP_W-1:0] MAIN_C  = STEP_W'(MAIN_STEPS);
    localparam logic [STEP_W-1:0] TOTAL_C = STEP_W'(TOTAL_STEPS);
    localparam logic [STEP_W-1:0] PARA_C  = STEP_W'(PARA_DEG);
    localparam logic [WI_W-1:0]   W_STEP  = WI_W'(PARA_DEG);
    localparam logic [WI_W-1:0]   W_LAST  = WI_W'(WEIGHT_NUMS - PARA_DEG);

    if ((PARA_DEG < 1) || ((WEIGHT_NUMS % PARA_DEG) != 0)) begin : g_bad_para
        $error("conv_step_sequencer: WEIGHT_NUMS must be a multiple of PARA_DEG");
    end
    if ((2 ** STEP_W) <= TOTAL_STEPS) begin : g_bad_step_w
        $error("conv_step_sequencer: STEP_W too narrow for TOTAL_STEPS");
    end

    logic [STEP_W-1:0] step_q, step_nxt;
    logic [WI_W-1:0]   w_q, w_nxt;
    logic [OI_W-1:0]   o_q, o_nxt;
    logic              tail_q, done_q;
    logic              dp_q, dp_nxt;

    always_comb begin
        step_nxt = step_q;
        w_nxt    = w_q;
        o_nxt    = o_q;
        dp_nxt   = 1'b0;
        if (Comp_Reset || !Computing) begin
            step_nxt = '0;
            w_nxt    = '0;
            o_nxt    = '0;
        end else if (!Stall && (step_q != TOTAL_C)) begin
            // Clamp the last stride so the count lands exactly on TOTAL_STEPS.
            step_nxt = (step_q >= (TOTAL_C - PARA_C)) ? TOTAL_C : (step_q + PARA_C);
            dp_nxt   = (step_nxt == TOTAL_C);
            // Indices only move inside the main phase; the tail keeps the last tap/output.
            if (step_nxt < MAIN_C) begin
                if (w_q == W_LAST) begin
                    w_nxt = '0;
                    o_nxt = o_q + OI_W'(1);
                end else begin
                    w_nxt = w_q + W_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            step_q <= '0;
            w_q    <= '0;
            o_q    <= '0;
            tail_q <= 1'b0;
            done_q <= 1'b0;
            dp_q   <= 1'b0;
        end else begin
            step_q <= step_nxt;
            w_q    <= w_nxt;
            o_q    <= o_nxt;
            tail_q <= (step_nxt >= MAIN_C) && (step_nxt < TOTAL_C);
            done_q <= (step_nxt == TOTAL_C);
            dp_q   <= dp_nxt;
        end
    end

    assign Step_Count  = step_q;
    assign Weight_Idx  = w_q;
    assign Output_Idx  = o_q;
    assign Tail_Active = tail_q;
    assign Comp_Done   = done_q;
    assign Done_Pulse  = dp_q;

    for (genvar i = 0; i < NUM_LVL; i++) begin : g_lvl
        lvl_step_counter #(
            .LVL_W (LVL_W),
            .LIMIT (int'(LVL_LIMITS[i*LVL_W +: LVL_W])),
            .WRAP  (LVL_WRAP[i])
        ) u_lvl (
            .clk        (clk),
            .Reset_n    (Reset_n),
            .clr        (Comp_Reset),
            .run        (Lvl_Ready[i]),
            .stall      (Stall),
            .count      (Lvl_Count[i*LVL_W +: LVL_W]),
            .last       (Lvl_Last[i]),
            .wrap_pulse (Lvl_Wrap_Pulse[i])
        );
    end

endmodule

// File: tb/tb_conv_step_sequencer.sv
// Bench for conv_step_sequencer: two configurations driven by shared stimulus and
// compared every cycle against an arithmetic reference model.
module tb_conv_step_sequencer;

    localparam int W     = 4;
    localparam int O     = 8;
    localparam int MAIN  = W * O;
    localparam int TOTAL = MAIN + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset_n, Comp_Reset, Computing, Stall;
    logic [1:0] Lvl_Ready;

    logic [5:0]  step_a, step_b;
    logic [1:0]  wi_a, wi_b;
    logic [2:0]  oi_a, oi_b;
    logic        tail_a, tail_b, done_a, done_b, dp_a, dp_b;
    logic [11:0] lc_a, lc_b;
    logic [1:0]  ll_a, ll_b, wp_a, wp_b;

    conv_step_sequencer dut_a (
        .clk(clk), .Reset_n(Reset_n), .Comp_Reset(Comp_Reset), .Computing(Computing),
        .Stall(Stall), .Lvl_Ready(Lvl_Ready), .Step_Count(step_a), .Weight_Idx(wi_a),
        .Output_Idx(oi_a), .Tail_Active(tail_a), .Comp_Done(done_a), .Done_Pulse(dp_a),
        .Lvl_Count(lc_a), .Lvl_Last(ll_a), .Lvl_Wrap_Pulse(wp_a)
    );

    conv_step_sequencer #(
        .PARA_DEG(2), .LVL_LIMITS({6'd1, 6'd19}), .LVL_WRAP(2'b11)
    ) dut_b (
        .clk(clk), .Reset_n(Reset_n), .Comp_Reset(Comp_Reset), .Computing(Computing),
        .Stall(Stall), .Lvl_Ready(Lvl_Ready), .Step_Count(step_b), .Weight_Idx(wi_b),
        .Output_Idx(oi_b), .Tail_Active(tail_b), .Comp_Done(done_b), .Done_Pulse(dp_b),
        .Lvl_Count(lc_b), .Lvl_Last(ll_b), .Lvl_Wrap_Pulse(wp_b)
    );

    int para [2]    = '{1, 2};
    int lim  [2][2] = '{'{19, 40}, '{19, 1}};
    bit wrp  [2][2] = '{'{0, 0}, '{1, 1}};

    int m_step [2];
    bit m_dp   [2];
    int m_cnt  [2][2];
    bit m_wp   [2][2];
    bit m_fresh;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_step[k] = 0;
            m_dp[k]   = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[k][i] = 0;
                m_wp[k][i]  = 0;
            end
        end
        m_fresh = 1;
    endtask

    task automatic model_edge();
        m_fresh = 0;
        for (int k = 0; k < 2; k++) begin
            m_dp[k] = 0;
            if (Comp_Reset || !Computing) begin
                m_step[k] = 0;
            end else if (!Stall && m_step[k] != TOTAL) begin
                m_step[k] = (m_step[k] + para[k] > TOTAL) ? TOTAL : m_step[k] + para[k];
                m_dp[k]   = (m_step[k] == TOTAL);
            end
            for (int i = 0; i < 2; i++) begin
                m_wp[k][i] = 0;
                if (Comp_Reset || !Lvl_Ready[i]) begin
                    m_cnt[k][i] = 0;
                end else if (!Stall) begin
                    if (m_cnt[k][i] < lim[k][i] - 1) begin
                        m_cnt[k][i]++;
                    end else if (wrp[k][i]) begin
                        m_cnt[k][i] = 0;
                        m_wp[k][i]  = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input int step, input int wi, input int oi,
                             input bit tail, input bit done, input bit dp,
                             input logic [11:0] lc, input logic [1:0] ll, input logic [1:0] wp);
        string p;
        int    s;
        p = (k == 0) ? "a." : "b.";
        s = m_step[k];
        chk({p, "step"}, step, s);
        chk({p, "widx"}, wi, (s < MAIN) ? s % W : W - para[k]);
        chk({p, "oidx"}, oi, (s < MAIN) ? s / W : O - 1);
        chk({p, "tail"}, int'(tail), int'(s >= MAIN && s < TOTAL));
        chk({p, "done"}, int'(done), int'(s == TOTAL));
        chk({p, "dpulse"}, int'(dp), int'(m_dp[k]));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%slvl%0d", p, i), int'(lc[i*6 +: 6]), m_cnt[k][i]);
            chk($sformatf("%slast%0d", p, i), int'(ll[i]),
                int'(!m_fresh && m_cnt[k][i] == lim[k][i] - 1));
            chk($sformatf("%swrap%0d", p, i), int'(wp[i]), int'(m_wp[k][i]));
        end
    endtask

    task automatic check_all();
        check_dut(0, step_a, wi_a, oi_a, tail_a, done_a, dp_a, lc_a, ll_a, wp_a);
        check_dut(1, step_b, wi_b, oi_b, tail_b, done_b, dp_b, lc_b, ll_b, wp_b);
    endtask

    task automatic step_cycle();
        @(posedge clk);
        if (Reset_n) model_edge();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step_cycle();
    endtask

    initial begin
        Reset_n    = 1'b0;
        Comp_Reset = 1'b0;
        Computing  = 1'b0;
        Stall      = 1'b0;
        Lvl_Ready  = 2'b00;
        model_reset();
        #12;
        check_all();

        // Free run from reset: full pass, done pulse, hold, level saturate/wrap.
        @(negedge clk);
        Reset_n   = 1'b1;
        Computing = 1'b1;
        Lvl_Ready = 2'b11;
        run(42);

        // Restart, stall for three cycles at step 10, then drop Computing at 20.
        Comp_Reset = 1'b1;
        step_cycle();
        Comp_Reset = 1'b0;
        run(10);
        Stall = 1'b1;
        run(3);
        Stall = 1'b0;
        run(10);
        Computing = 1'b0;
        step_cycle();
        Computing = 1'b1;
        run(5);

        // Asynchronous reset mid-count, held across an edge, then resume.
        Comp_Reset = 1'b1;
        step_cycle();
        Comp_Reset = 1'b0;
        Lvl_Ready  = 2'b00;
        run(5);
        Lvl_Ready = 2'b11;
        run(7);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step_cycle();
        Reset_n = 1'b1;
        run(6);

        // Randomised traffic.
        for (int j = 0; j < 500; j++) begin
            Computing  = ($urandom_range(0, 59) != 0);
            Stall      = ($urandom_range(0, 4) == 0);
            Comp_Reset = ($urandom_range(0, 79) == 0);
            Lvl_Ready  = {1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 15) != 0)};
            step_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
